// File: rtl/fsm_trace_checker_if.sv
// Trace-bus bundle between the trace source and fsm_trace_checker.
// The master drives the sampled trace and clear; the checker returns its status.
interface fsm_trace_checker_if;
  logic        sample_en;
  logic [2:0]  state_in;
  logic [7:0]  led_in;
  logic        clear;
  logic        synced;
  logic [3:0]  state_onehot;
  logic        err_pulse;
  logic [3:0]  err_flags;
  logic [7:0]  err_count;
  logic [15:0] rounds;

  modport master (
    output sample_en, state_in, led_in, clear,
    input  synced, state_onehot, err_pulse, err_flags, err_count, rounds
  );

  modport slave (
    input  sample_en, state_in, led_in, clear,
    output synced, state_onehot, err_pulse, err_flags, err_count, rounds
  );
endinterface

// File: rtl/fsm_trace_checker.sv
// Receive-side monitor for the FSM trace bus: locks onto IDLE->COUNT->WAIT->DONE,
// checks transitions, LED codes and COUNT dwell, and keeps sticky debug status.
module fsm_trace_checker #(
  parameter int unsigned COUNT_DWELL = 4,
  parameter bit          LED_LAG     = 1'b0
) (
  input logic               clk,
  input logic               reset,
  fsm_trace_checker_if.slave bus
);
  typedef enum logic {UNSYNC, TRACK} tracker_e;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [7:0] DWELL   = 8'(COUNT_DWELL);

  function automatic logic [7:0] led_code(input logic [1:0] s);
    case (s)
      S_IDLE:  led_code = 8'h00;
      S_COUNT: led_code = 8'h0A;
      S_WAIT:  led_code = 8'h05;
      default: led_code = 8'h0F;
    endcase
  endfunction

  tracker_e    tracker_q, tracker_d;
  logic [1:0]  prev_q, prev_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        first_q, first_d;
  logic [3:0]  onehot_q, onehot_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] rounds_q, rounds_d;
  logic        pulse_q, pulse_d;

  logic       code_valid, legal;
  logic [1:0] cur;
  logic       err_trans, err_code, err_led, err_dwell;

  assign cur        = bus.state_in[1:0];
  assign code_valid = ~bus.state_in[2];
  // The cycle order equals code order, so a legal step is "same" or "+1 mod 4".
  assign legal      = (cur == prev_q) || (cur == 2'(prev_q + 2'd1));

  // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    tracker_d = tracker_q;
    prev_d    = prev_q;
    dwell_d   = dwell_q;
    first_d   = first_q;
    onehot_d  = onehot_q;
    flags_d   = flags_q;
    count_d   = count_q;
    rounds_d  = rounds_q;
    pulse_d   = 1'b0;
    err_trans = 1'b0;
    err_code  = 1'b0;
    err_led   = 1'b0;
    err_dwell = 1'b0;

    if (bus.clear) begin
      tracker_d = UNSYNC;
      prev_d    = S_IDLE;
      dwell_d   = 8'd0;
      first_d   = 1'b0;
      flags_d   = 4'd0;
      count_d   = 8'd0;
      rounds_d  = 16'd0;
    end else if (bus.sample_en) begin
      if (code_valid) onehot_d = 4'b0001 << cur;

      if (tracker_q == UNSYNC) begin
        if (bus.state_in == 3'd0) begin
          tracker_d = TRACK;
          prev_d    = S_IDLE;
          dwell_d   = 8'd0;
          first_d   = 1'b1;
        end
      end else begin
        first_d = 1'b0;
        if (!code_valid)  err_code  = 1'b1;
        else if (!legal)  err_trans = 1'b1;

        if (LED_LAG) begin
          if (!first_q && bus.led_in != led_code(prev_q)) err_led = 1'b1;
        end else if (code_valid && bus.led_in != led_code(cur)) begin
          err_led = 1'b1;
        end

        // Dwell counts the current COUNT sample; overrun fires once, on the step past the limit.
        if (code_valid && cur == S_COUNT) begin
          if (prev_q != S_COUNT) begin
            dwell_d = 8'd1;
          end else if (dwell_q != 8'hFF) begin
            dwell_d = 8'(dwell_q + 8'd1);
            if (dwell_q == DWELL) err_dwell = 1'b1;
          end
        end
        if (code_valid && prev_q == S_COUNT && cur == S_WAIT && dwell_q < DWELL) err_dwell = 1'b1;

        if (code_valid && legal && prev_q == S_DONE && cur == S_IDLE && rounds_q != 16'hFFFF)
          rounds_d = 16'(rounds_q + 16'd1);

        if (code_valid) prev_d = cur;
        if (err_trans || err_code) tracker_d = UNSYNC;

        flags_d = flags_q | {err_dwell, err_led, err_code, err_trans};
        pulse_d = err_trans | err_code | err_led | err_dwell;
        if (pulse_d && count_q != 8'hFF) count_d = 8'(count_q + 8'd1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tracker_q <= UNSYNC;
      prev_q    <= S_IDLE;
      dwell_q   <= 8'd0;
      first_q   <= 1'b0;
      onehot_q  <= 4'd0;
      flags_q   <= 4'd0;
      count_q   <= 8'd0;
      rounds_q  <= 16'd0;
      pulse_q   <= 1'b0;
    end else begin
      tracker_q <= tracker_d;
      prev_q    <= prev_d;
      dwell_q   <= dwell_d;
      first_q   <= first_d;
      onehot_q  <= onehot_d;
      flags_q   <= flags_d;
      count_q   <= count_d;
      rounds_q  <= rounds_d;
      pulse_q   <= pulse_d;
    end
  end

  assign bus.synced       = (tracker_q == TRACK);
  assign bus.state_onehot = onehot_q;
  assign bus.err_pulse    = pulse_q;
  assign bus.err_flags    = flags_q;
  assign bus.err_count    = count_q;
  assign bus.rounds       = rounds_q;
endmodule

// File: tb/tb_fsm_trace_checker.sv
// Directed bench for fsm_trace_checker (COUNT_DWELL=4, LED_LAG=0) with
// hand-computed expectations for each trace scenario.
module tb_fsm_trace_checker;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_passed = 0;
  logic pulse_seen;

  localparam logic [2:0] IDLE = 3'd0, COUNT = 3'd1, WAIT = 3'd2, DONE = 3'd3;
  localparam logic [7:0] L_IDLE = 8'h00, L_COUNT = 8'h0A, L_WAIT = 8'h05, L_DONE = 8'h0F;

  fsm_trace_checker_if bus ();

  fsm_trace_checker #(.COUNT_DWELL(4), .LED_LAG(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one sample for one rising edge; outputs are sampled 1 time unit after it.
  task automatic smp(input logic [2:0] s, input logic [7:0] l);
    bus.sample_en = 1'b1;
    bus.state_in  = s;
    bus.led_in    = l;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    pulse_seen |= bus.err_pulse;
  endtask

  task automatic do_clear(input logic with_sample);
    bus.clear     = 1'b1;
    bus.sample_en = with_sample;
    bus.state_in  = IDLE;
    bus.led_in    = L_IDLE;
    @(posedge clk); #1;
    bus.clear     = 1'b0;
    bus.sample_en = 1'b0;
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.state_in  = 3'd0;
    bus.led_in    = 8'd0;
    bus.clear     = 1'b0;
    pulse_seen    = 1'b0;
    reset         = 1'b0;
    #1;
    check("rst_synced", 32'(bus.synced), 32'd0);
    check("rst_onehot", 32'(bus.state_onehot), 32'd0);
    check("rst_pulse",  32'(bus.err_pulse), 32'd0);
    check("rst_flags",  32'(bus.err_flags), 32'd0);
    check("rst_count",  32'(bus.err_count), 32'd0);
    check("rst_rounds", 32'(bus.rounds), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Clean round
    smp(IDLE, L_IDLE);
    check("sync_synced", 32'(bus.synced), 32'd1);
    smp(IDLE, L_IDLE);
    for (int i = 0; i < 4; i++) smp(COUNT, L_COUNT);
    check("round_onehot_count", 32'(bus.state_onehot), 32'b0010);
    for (int i = 0; i < 3; i++) smp(WAIT, L_WAIT);
    for (int i = 0; i < 2; i++) smp(DONE, L_DONE);
    smp(IDLE, L_IDLE);
    check("round_synced", 32'(bus.synced), 32'd1);
    check("round_flags",  32'(bus.err_flags), 32'd0);
    check("round_rounds", 32'(bus.rounds), 32'd1);
    check("round_nopulse", 32'(pulse_seen), 32'd0);
    check("round_onehot", 32'(bus.state_onehot), 32'b0001);

    // Illegal COUNT->DONE
    smp(COUNT, L_COUNT);
    smp(DONE, L_DONE);
    check("illeg_flags",  32'(bus.err_flags), 32'b0001);
    check("illeg_pulse",  32'(bus.err_pulse), 32'd1);
    check("illeg_count",  32'(bus.err_count), 32'd1);
    check("illeg_synced", 32'(bus.synced), 32'd0);
    check("illeg_onehot", 32'(bus.state_onehot), 32'b1000);
    @(posedge clk); #1;
    check("illeg_pulse_drop", 32'(bus.err_pulse), 32'd0);
    smp(IDLE, L_IDLE);
    check("resync", 32'(bus.synced), 32'd1);

    // Dwell overrun
    do_clear(1'b0);
    check("clr_rounds", 32'(bus.rounds), 32'd0);
    smp(IDLE, L_IDLE);
    for (int i = 0; i < 4; i++) smp(COUNT, L_COUNT);
    check("over_4_flags", 32'(bus.err_flags), 32'd0);
    smp(COUNT, L_COUNT);
    check("over_5_flags", 32'(bus.err_flags), 32'b1000);
    check("over_5_pulse", 32'(bus.err_pulse), 32'd1);
    check("over_5_count", 32'(bus.err_count), 32'd1);
    smp(COUNT, L_COUNT);
    check("over_6_pulse",  32'(bus.err_pulse), 32'd0);
    check("over_6_count",  32'(bus.err_count), 32'd1);
    check("over_6_synced", 32'(bus.synced), 32'd1);
    smp(WAIT, L_WAIT);
    check("over_wait_count", 32'(bus.err_count), 32'd1);

    // Dwell underrun
    do_clear(1'b0);
    smp(IDLE, L_IDLE);
    smp(COUNT, L_COUNT);
    smp(COUNT, L_COUNT);
    check("under_pre", 32'(bus.err_flags), 32'd0);
    smp(WAIT, L_WAIT);
    check("under_flags",  32'(bus.err_flags), 32'b1000);
    check("under_pulse",  32'(bus.err_pulse), 32'd1);
    check("under_synced", 32'(bus.synced), 32'd1);

    // Invalid code while synced
    smp(3'd5, 8'hFF);
    check("inv_flags",  32'(bus.err_flags), 32'b1010);
    check("inv_count",  32'(bus.err_count), 32'd2);
    check("inv_synced", 32'(bus.synced), 32'd0);
    check("inv_onehot", 32'(bus.state_onehot), 32'b0100);

    // LED mismatch without resync, hold, then clear beating a sample
    do_clear(1'b0);
    smp(IDLE, L_IDLE);
    for (int i = 0; i < 4; i++) smp(COUNT, L_COUNT);
    smp(WAIT, L_COUNT);
    check("led_flags",  32'(bus.err_flags), 32'b0100);
    check("led_synced", 32'(bus.synced), 32'd1);
    check("led_count",  32'(bus.err_count), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_flags", 32'(bus.err_flags), 32'b0100);
    check("hold_pulse", 32'(bus.err_pulse), 32'd0);
    do_clear(1'b1);
    check("clr_flags",  32'(bus.err_flags), 32'd0);
    check("clr_count",  32'(bus.err_count), 32'd0);
    check("clr_synced", 32'(bus.synced), 32'd0);
    check("clr_onehot", 32'(bus.state_onehot), 32'b0100);

    // err_count saturation: each pair is sync then invalid code
    for (int i = 0; i < 300; i++) begin
      smp(IDLE, L_IDLE);
      smp(3'd7, 8'h00);
      if (i == 9) check("sat_10", 32'(bus.err_count), 32'd10);
    end
    check("sat_255", 32'(bus.err_count), 32'd255);

    // Asynchronous reset in the middle of COUNT
    do_clear(1'b0);
    smp(IDLE, L_IDLE);
    smp(COUNT, L_COUNT);
    smp(COUNT, L_COUNT);
    smp(COUNT, L_COUNT);
    smp(COUNT, L_COUNT);
    smp(COUNT, L_COUNT);
    #2 reset = 1'b0;
    #1;
    check("arst_synced", 32'(bus.synced), 32'd0);
    check("arst_onehot", 32'(bus.state_onehot), 32'd0);
    check("arst_flags",  32'(bus.err_flags), 32'd0);
    check("arst_count",  32'(bus.err_count), 32'd0);
    check("arst_pulse",  32'(bus.err_pulse), 32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    smp(COUNT, L_COUNT);
    check("arst_nosync", 32'(bus.synced), 32'd0);
    smp(IDLE, L_IDLE);
    check("arst_resync", 32'(bus.synced), 32'd1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
